// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider issue controller.
//   WordW          : datapath word width (operands, quotient, remainder)
//   MinLatDefault  : default number of post-acceptance cycles in which the
//                    divider's completion flag is not trustworthy
//   div_state_e    : controller state encoding
package div_ctrl_pkg;

  localparam int unsigned WordW         = 32;
  localparam int unsigned MinLatDefault = 2;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StDrain
  } div_state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request/response bundle between the issue controller and the iterative divider.
//   master : controller side (drives request, observes acceptance/result)
//   slave  : divider side
//   div_valid / div_signed_o / div_x / div_y : request and operands
//   div_tready   : divider accepted the request this cycle
//   div_complete : divider result valid (also high while idle / just loaded)
//   div_s / div_r: quotient / remainder
interface div_issue_ctrl_if;
  import div_ctrl_pkg::*;

  logic             div_valid;
  logic             div_signed_o;
  logic [WordW-1:0] div_x;
  logic [WordW-1:0] div_y;
  logic             div_tready;
  logic             div_complete;
  logic [WordW-1:0] div_s;
  logic [WordW-1:0] div_r;

  modport master (
    output div_valid, div_signed_o, div_x, div_y,
    input  div_tready, div_complete, div_s, div_r
  );

  modport slave (
    input  div_valid, div_signed_o, div_x, div_y,
    output div_tready, div_complete, div_s, div_r
  );

endinterface

// File: rtl/div_lat_cnt.sv
// Saturating latency guard counter, synchronous active-low reset.
//   clr_i : force count to zero
//   en_i  : increment (holds once MaxVal is reached)
//   cnt_o : current count
//   sat_o : count has reached MaxVal
module div_lat_cnt #(
  parameter int unsigned MaxVal = 2,
  parameter int unsigned CntW   = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic            sat_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign sat_o = (cnt_q == CntW'(MaxVal));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Execute-stage initiator for the iterative divider.
// Accepts DIV/DIVU from EX, latches operands, issues them to the divider, waits for
// completion and writes quotient to LO and remainder to HI. Stalls EX while a divide
// is outstanding; a flush after acceptance drains and discards the in-flight result.
// Ports:
//   div_clk, resetn          : clock, synchronous active-low reset
//   ex_valid/ex_div_op/...   : EX instruction, operands and flush
//   ex_stall                 : hold EX
//   div_bus (master)         : divider request/response bundle
//   hi_we/lo_we/hi_wdata/lo_wdata : HI/LO write port
//   busy                     : controller not idle
// Build option: DIV_ZERO_BYPASS_EN -- a zero divisor skips the divider and writes
//   LO=all-ones, HI=dividend directly.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned MIN_LAT = MinLatDefault,
  parameter int unsigned CNT_W   = 3
) (
  input  logic                   div_clk,
  input  logic                   resetn,
  input  logic                   ex_valid,
  input  logic                   ex_div_op,
  input  logic                   ex_signed,
  input  logic [WordW-1:0]       ex_src1,
  input  logic [WordW-1:0]       ex_src2,
  input  logic                   ex_flush,
  output logic                   ex_stall,
  div_issue_ctrl_if.master       div_bus,
  output logic                   hi_we,
  output logic                   lo_we,
  output logic [WordW-1:0]       hi_wdata,
  output logic [WordW-1:0]       lo_wdata,
  output logic                   busy
);

  div_state_e       state_d, state_q;
  logic [WordW-1:0] op_x_d, op_x_q;
  logic [WordW-1:0] op_y_d, op_y_q;
  logic             op_signed_d, op_signed_q;
  logic [WordW-1:0] res_s_d, res_s_q;
  logic [WordW-1:0] res_r_d, res_r_q;

  logic             accept;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_val;
  logic             guard_done;
  logic             div_valid;

  div_lat_cnt #(
    .MaxVal (MIN_LAT),
    .CntW   (CNT_W)
  ) u_lat_cnt (
    .clk_i  (div_clk),
    .rst_ni (resetn),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .cnt_o  (cnt_val),
    .sat_o  (cnt_sat)
  );

  assign accept     = ex_valid && ex_div_op && !ex_flush;
  // The divider flags complete while idle or just loaded; trust it only after MIN_LAT.
  assign guard_done = cnt_sat && div_bus.div_complete;

  always_comb begin
    state_d     = state_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    op_signed_d = op_signed_q;
    res_s_d     = res_s_q;
    res_r_d     = res_r_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    ex_stall    = 1'b0;
    div_valid   = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        ex_stall = accept;
        if (accept) begin
          op_x_d      = ex_src1;
          op_y_d      = ex_src2;
          op_signed_d = ex_signed;
          state_d     = StReq;
`ifdef DIV_ZERO_BYPASS_EN
          if (ex_src2 == '0) begin
            res_s_d = '1;
            res_r_d = ex_src1;
            state_d = StDone;
          end
`endif
        end
      end
      StReq: begin
        div_valid = 1'b1;
        ex_stall  = 1'b1;
        cnt_clr   = 1'b1;
        if (ex_flush) begin
          // Once accepted the divider cannot be cancelled, so its result must be drained.
          state_d = div_bus.div_tready ? StDrain : StIdle;
        end else if (div_bus.div_tready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        ex_stall = 1'b1;
        cnt_en   = 1'b1;
        if (ex_flush) begin
          state_d = StDrain;
        end else if (guard_done) begin
          res_s_d = div_bus.div_s;
          res_r_d = div_bus.div_r;
          state_d = StDone;
        end
      end
      StDone: begin
        hi_we   = !ex_flush;
        lo_we   = !ex_flush;
        state_d = StIdle;
      end
      StDrain: begin
        cnt_en   = 1'b1;
        ex_stall = ex_valid && ex_div_op;
        if (guard_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      op_x_q      <= '0;
      op_y_q      <= '0;
      op_signed_q <= 1'b0;
      res_s_q     <= '0;
      res_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      op_signed_q <= op_signed_d;
      res_s_q     <= res_s_d;
      res_r_q     <= res_r_d;
    end
  end

  assign div_bus.div_valid    = div_valid;
  assign div_bus.div_signed_o = op_signed_q;
  assign div_bus.div_x        = op_x_q;
  assign div_bus.div_y        = op_y_q;
  assign hi_wdata             = res_r_q;
  assign lo_wdata             = res_s_q;
  assign busy                 = (state_q != StIdle);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: a bench-side divider, an EX instruction
// stream that holds while stalled, and a transaction-level controller model checked
// every cycle, followed by directed scenarios with literal expectations.
module tb_div_issue_ctrl;
  import div_ctrl_pkg::*;

  localparam int unsigned MinLat = 2;

  logic        div_clk = 1'b0;
  logic        resetn;
  logic        ex_valid, ex_div_op, ex_signed, ex_flush;
  logic [31:0] ex_src1, ex_src2;
  logic        ex_stall, hi_we, lo_we, busy;
  logic [31:0] hi_wdata, lo_wdata;

  div_issue_ctrl_if dbus ();

  div_issue_ctrl #(
    .MIN_LAT (MinLat),
    .CNT_W   (3)
  ) dut (
    .div_clk   (div_clk),
    .resetn    (resetn),
    .ex_valid  (ex_valid),
    .ex_div_op (ex_div_op),
    .ex_signed (ex_signed),
    .ex_src1   (ex_src1),
    .ex_src2   (ex_src2),
    .ex_flush  (ex_flush),
    .ex_stall  (ex_stall),
    .div_bus   (dbus.master),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .hi_wdata  (hi_wdata),
    .lo_wdata  (lo_wdata),
    .busy      (busy)
  );

  always #5 div_clk = ~div_clk;

  int errors = 0;
  int checks = 0;

  // EX instruction currently presented, and one-cycle control requests
  logic        in_valid = 0, in_div = 0, in_sgn = 0;
  logic [31:0] in_x = 0, in_y = 0;
  logic        nx_flush = 0, nx_rst = 0;
  bit          rnd_mode = 0;

  // Bench divider
  bit          e_busy = 0;
  int          e_age = 0, e_lat = 3;
  logic [31:0] e_q = 0, e_r = 0;

  // Controller model: an op is pending until resolved; sent once the divider took it;
  // killed if flushed after being sent; wb is the single write-back cycle.
  bit          m_pending = 0, m_sent = 0, m_kill = 0, m_wb = 0;
  int          m_age = 0;
  logic [31:0] m_x = 0, m_y = 0, m_q = 0, m_r = 0;
  logic        m_sgn = 0;

  // Observations for directed checks
  int          wr_cnt, stall_low, dv_seen;
  logic [31:0] obs_hi, obs_lo;

  function automatic logic [63:0] div_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic sgn);
    logic [31:0] q, r;
    if (y == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = x;
    end else if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        q = x;
        r = 32'd0;
      end else begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end
    end else begin
      q = x / y;
      r = x % y;
    end
    return {r, q};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic p_stall, p_valid, p_we, p_busy, guard, retire;
    @(negedge div_clk);
    resetn    = !nx_rst;
    ex_flush  = nx_flush;
    ex_valid  = in_valid;
    ex_div_op = in_div;
    ex_signed = in_sgn;
    ex_src1   = in_x;
    ex_src2   = in_y;
    if (e_busy) begin
      dbus.div_tready   = 1'b0;
      dbus.div_complete = (e_age < 2);
      dbus.div_s        = $urandom();
      dbus.div_r        = $urandom();
    end else begin
      dbus.div_tready   = 1'($urandom_range(0, 1));
      dbus.div_complete = 1'b1;
      dbus.div_s        = e_q;
      dbus.div_r        = e_r;
    end
    #2;
    p_valid = m_pending && !m_sent;
    p_we    = m_wb && !ex_flush;
    p_busy  = m_pending || m_wb;
    if (m_wb)                      p_stall = 1'b0;
    else if (m_pending && !m_kill) p_stall = 1'b1;
    else if (m_kill)               p_stall = ex_valid && ex_div_op;
    else                           p_stall = ex_valid && ex_div_op && !ex_flush;
    chk("busy", busy, p_busy);
    chk("ex_stall", ex_stall, p_stall);
    chk("div_valid", dbus.div_valid, p_valid);
    chk("hi_we", hi_we, p_we);
    chk("lo_we", lo_we, p_we);
    if (p_valid) begin
      chk("div_x", dbus.div_x, m_x);
      chk("div_y", dbus.div_y, m_y);
      chk("div_signed", dbus.div_signed_o, m_sgn);
    end
    if (p_we) begin
      chk("hi_wdata", hi_wdata, m_r);
      chk("lo_wdata", lo_wdata, m_q);
    end
    if (hi_we) begin
      wr_cnt++;
      obs_hi = hi_wdata;
      obs_lo = lo_wdata;
    end
    if (busy && !ex_stall) stall_low++;
    if (dbus.div_valid) dv_seen++;
    retire = nx_rst || ex_flush || !p_stall;

    @(posedge div_clk);
    if (nx_rst) begin
      m_pending = 0; m_sent = 0; m_kill = 0; m_wb = 0;
      e_busy = 0;
    end else begin
      guard = (m_age >= MinLat) && dbus.div_complete;
      if (m_wb) begin
        m_wb = 0;
      end else if (!m_pending) begin
        if (ex_valid && ex_div_op && !ex_flush) begin
          m_x = ex_src1; m_y = ex_src2; m_sgn = ex_signed;
          m_pending = 1; m_sent = 0; m_kill = 0;
`ifdef DIV_ZERO_BYPASS_EN
          if (ex_src2 == 32'd0) begin
            m_pending = 0;
            m_wb = 1;
            {m_r, m_q} = div_ref(m_x, m_y, m_sgn);
          end
`endif
        end
      end else if (!m_sent) begin
        if (dbus.div_tready) begin
          m_sent = 1; m_age = 0; m_kill = ex_flush;
          e_busy = 1; e_age = 0; e_lat = $urandom_range(3, 6);
          {e_r, e_q} = div_ref(m_x, m_y, m_sgn);
        end else if (ex_flush) begin
          m_pending = 0;
        end
      end else begin
        if (!m_kill && ex_flush) begin
          m_kill = 1;
        end else if (guard) begin
          m_pending = 0;
          if (!m_kill) begin
            m_wb = 1;
            {m_r, m_q} = div_ref(m_x, m_y, m_sgn);
          end
          m_kill = 0;
          m_sent = 0;
        end
        m_age++;
      end
      if (e_busy && !(p_valid && dbus.div_tready)) begin
        e_age++;
        if (e_age >= e_lat) e_busy = 0;
      end
    end
    if (retire) begin
      if (rnd_mode) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_div   = 1'($urandom_range(0, 1));
        in_sgn   = 1'($urandom_range(0, 1));
        in_x     = ($urandom_range(0, 1) != 0) ? $urandom() : 32'($urandom_range(0, 200));
        case ($urandom_range(0, 4))
          0:       in_y = 32'd0;
          1:       in_y = 32'hFFFF_FFFF;
          2:       in_y = $urandom();
          default: in_y = 32'($urandom_range(1, 20));
        endcase
      end else begin
        in_valid = 0;
      end
    end
    nx_flush = 0;
    nx_rst   = 0;
  endtask

  // Present one divide and run until it leaves EX; flush_at/rst_at count cycles
  // after the divider accepted it (-1 disables).
  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                        input int flush_at, input int rst_at);
    int acc_age;
    int n;
    in_valid = 1; in_div = 1; in_sgn = sgn; in_x = x; in_y = y;
    wr_cnt = 0; stall_low = 0; dv_seen = 0; acc_age = -1;
    n = 0;
    while (in_valid && n < 60) begin
      nx_flush = (acc_age >= 0 && acc_age == flush_at);
      nx_rst   = (acc_age >= 0 && acc_age == rst_at);
      cycle();
      if (acc_age >= 0) acc_age++;
      else if (m_sent) acc_age = 1;
      n++;
    end
    chk("do_div_timeout", {31'd0, in_valid}, 32'd0);
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) cycle();
  endtask

  initial begin
    resetn = 0; ex_valid = 0; ex_div_op = 0; ex_signed = 0; ex_flush = 0;
    ex_src1 = 0; ex_src2 = 0;
    dbus.div_tready = 0; dbus.div_complete = 0; dbus.div_s = 0; dbus.div_r = 0;
    repeat (2) @(posedge div_clk);
    @(negedge div_clk);
    chk("rst_busy", busy, 0);
    chk("rst_hi_we", hi_we, 0);
    chk("rst_div_valid", dbus.div_valid, 0);
    chk("rst_hi_wdata", hi_wdata, 0);
    chk("rst_lo_wdata", lo_wdata, 0);
    chk("rst_div_x", dbus.div_x, 0);

    // Signed -7/2
    do_div(32'hFFFF_FFF9, 32'd2, 1, -1, -1);
    chk("sdiv_writes", wr_cnt, 1);
    chk("sdiv_lo", obs_lo, 32'hFFFF_FFFD);
    chk("sdiv_hi", obs_hi, 32'hFFFF_FFFF);
    chk("sdiv_stall_low", stall_low, 1);

    // Unsigned
    do_div(32'd100, 32'd7, 0, -1, -1);
    chk("udiv1_lo", obs_lo, 32'h0000_000E);
    chk("udiv1_hi", obs_hi, 32'h0000_0002);
    do_div(32'h8000_0000, 32'd2, 0, -1, -1);
    chk("udiv2_lo", obs_lo, 32'h4000_0000);
    chk("udiv2_hi", obs_hi, 32'h0000_0000);

    // Flush three cycles after acceptance, then DIV 9/3 waits out the drain
    do_div(32'd50, 32'd5, 0, 3, -1);
    chk("flush_writes", wr_cnt, 0);
    do_div(32'd9, 32'd3, 1, -1, -1);
    chk("after_flush_writes", wr_cnt, 1);
    chk("after_flush_lo", obs_lo, 32'd3);
    chk("after_flush_hi", obs_hi, 32'd0);

    // Back-to-back
    do_div(32'd20, 32'd3, 1, -1, -1);
    chk("b2b1_lo", obs_lo, 32'd6);
    chk("b2b1_hi", obs_hi, 32'd2);
    do_div(32'hFFFF_FFF0, 32'hFFFF_FFFF, 1, -1, -1);
    chk("b2b2_lo", obs_lo, 32'd16);
    chk("b2b2_hi", obs_hi, 32'd0);

    // Reset in the middle of WAIT
    do_div(32'h1000, 32'd3, 0, -1, 2);
    chk("rst_mid_writes", wr_cnt, 0);
    cycle();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hi_we", hi_we, 0);
    do_div(32'd5, 32'd5, 0, -1, -1);
    chk("post_rst_lo", obs_lo, 32'd1);
    chk("post_rst_hi", obs_hi, 32'd0);

    // Zero divisor
    do_div(32'h0000_1234, 32'd0, 1, -1, -1);
    chk("zero_lo", obs_lo, 32'hFFFF_FFFF);
    chk("zero_hi", obs_hi, 32'h0000_1234);
`ifdef DIV_ZERO_BYPASS_EN
    chk("zero_no_valid", dv_seen, 0);
`endif

    // Randomized traffic against the model
    settle();
    rnd_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      nx_flush = ($urandom_range(0, 19) == 0);
      nx_rst   = ($urandom_range(0, 299) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
Initiator side of the iterative divider handshake, placed in the execute stage of the CPU pipeline. Accepts DIV/DIVU from EX and latches the operands. Drives the divider's valid/signed/operand inputs, waits for its completion, and writes quotient to LO and remainder to HI. Stalls EX while a divide is outstanding and handles pipeline flush mid-operation by draining and discarding the in-flight result.

Parameters:
MIN_LAT, 2, cycles after divider acceptance during which div_complete is ignored (divider reports complete=1 while idle/just loaded)
CNT_W, 3, width of the latency guard counter; must hold MIN_LAT

Ports:
div_clk  in  1  clock
resetn  in  1  synchronous active-low reset
ex_valid  in  1  EX stage holds a valid instruction
ex_div_op  in  1  EX instruction is DIV/DIVU
ex_signed  in  1  1=DIV, 0=DIVU
ex_src1  in  32  dividend
ex_src2  in  32  divisor
ex_flush  in  1  exception/ERET flush of EX this cycle
ex_stall  out  1  hold EX (divide not yet written back)
div_valid  out  1  request to divider (its tvalid input)
div_signed_o  out  1  signedness to divider
div_x  out  32  dividend to divider
div_y  out  32  divisor to divider
div_tready  in  1  divider accepted request this cycle
div_complete  in  1  divider result valid
div_s  in  32  quotient
div_r  in  32  remainder
hi_we  out  1  HI write strobe
lo_we  out  1  LO write strobe
hi_wdata  out  32  HI data (remainder)
lo_wdata  out  32  LO data (quotient)
busy  out  1  state != IDLE

Behaviour:
- Clock div_clk; reset synchronous, active-low on resetn; all state updated only at posedge div_clk.
- Reset: state=IDLE, all outputs 0, latched operands 0, counter 0.
- IDLE: ex_valid&&ex_div_op&&!ex_flush -> latch src1/src2/signed, go REQ. ex_stall=1 combinationally in that cycle.
- REQ: div_valid=1; div_x/div_y/div_signed_o driven from latches and held stable until acceptance. On div_tready -> WAIT, counter=0. On ex_flush: if div_tready in same cycle -> DRAIN, else -> IDLE with request dropped. ex_stall=1.
- WAIT: div_valid=0. Counter increments, saturating at MIN_LAT. When counter==MIN_LAT && div_complete -> capture div_s/div_r into output regs, go DONE. ex_flush -> DRAIN. ex_stall=1.
- DONE: hi_we=lo_we=1 for exactly one cycle, hi_wdata=captured r, lo_wdata=captured s; ex_stall=0; go IDLE. ex_flush in DONE suppresses both strobes.
- DRAIN: divider cannot be cancelled. Wait for counter==MIN_LAT && div_complete, discard result, go IDLE. No HI/LO writes. ex_stall=ex_valid&&ex_div_op; otherwise 0.
- Latency: issue to HI/LO write is 1 (REQ) + divider latency + 1 (DONE). Back-to-back divides re-enter REQ from IDLE on the cycle after DONE.
- Operand latches are written only in IDLE on accept; EX operand changes after accept are ignored.
- div_complete outside WAIT/DRAIN is ignored.
- Reset mid-operation returns to IDLE. The divider is reset by the same resetn, so there is no stale completion.

Optional Feature:
DIV_ZERO_BYPASS_EN: when defined, a request with latched divisor==0 skips the divider: IDLE -> DONE directly, LO=0xFFFFFFFF, HI=dividend, div_valid never asserted. Without the macro, zero divisors are issued to the divider like any other operand and its result is written.

Decomposition:
- Package div_ctrl_pkg: state encoding (IDLE, REQ, WAIT, DONE, DRAIN), MIN_LAT default, 32-bit word width constant.
- No sub-module is required. The saturating latency guard counter may be split out as div_lat_cnt if reused by the multiplier controller.

Test Plan:
- Signed: DIV -7/2 -> one hi_we/lo_we pulse, LO=0xFFFFFFFD, HI=0xFFFFFFFF, ex_stall low in the DONE cycle only.
- Unsigned: DIVU 100/7 -> LO=0x0000000E, HI=0x00000002; DIVU 0x80000000/2 -> LO=0x40000000, HI=0.
- Flush in WAIT: ex_flush 3 cycles after acceptance -> no HI/LO write. A following DIV 9/3 stalls until DRAIN ends, then LO=3, HI=0.
- Back-to-back: 20/3 then 0xFFFFFFF0/0xFFFFFFFF (signed, -16/-1) -> two write pulses in order, LO=6/HI=2 then LO=16/HI=0.
- Reset mid-WAIT: resetn=0 for 1 cycle -> next cycle busy=0, all strobes 0. A subsequent DIVU 5/5 gives LO=1, HI=0.
- With DIV_ZERO_BYPASS_EN: DIV 0x1234/0 -> div_valid never high, LO=0xFFFFFFFF, HI=0x00001234 two cycles after issue.
